// File: rtl/ifid_fetch_pipe_if.sv
// Fetch-side bundle between the hazard/control unit, instruction memory and the
// IF/ID stage. The pipe takes the slave view.
interface ifid_fetch_pipe_if #(
    parameter int CNT_W = 16
);
    logic             PC_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             Branch2;
    logic [31:0]      BranchTarget;
    logic             Jump;
    logic [31:0]      JumpTarget;
    logic [31:0]      Instr_in;
    logic [31:0]      PC;
    logic [31:0]      IFID_Instr;
    logic [31:0]      IFID_PC4;
    logic             IFID_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output PC_write, IFID_write, IFID_flush, Branch2, BranchTarget,
               Jump, JumpTarget, Instr_in,
        input  PC, IFID_Instr, IFID_PC4, IFID_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  PC_write, IFID_write, IFID_flush, Branch2, BranchTarget,
               Jump, JumpTarget, Instr_in,
        output PC, IFID_Instr, IFID_PC4, IFID_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ifid_fetch_pipe.sv
// Program counter and IF/ID pipeline register with stall/flush/redirect control
// and saturating debug counters for stall and flush cycles.
module ifid_fetch_pipe #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ifid_fetch_pipe_if.slave      bus
);

    logic [31:0]      pc_r;
    logic [31:0]      pc4_s;
    logic [31:0]      next_pc_s;
    logic [31:0]      ifid_instr_r;
    logic [31:0]      ifid_instr_nxt_s;
    logic [31:0]      ifid_pc4_r;
    logic [31:0]      ifid_pc4_nxt_s;
    logic             ifid_valid_r;
    logic             ifid_valid_nxt_s;
    logic             stall_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_nxt_s;
    logic [CNT_W-1:0] flush_cnt_r;
    logic [CNT_W-1:0] flush_cnt_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign pc4_s = pc_r + 32'd4;
    // A resolved branch is older than any stall cause, so it bypasses PC_write
    assign stall_s = !bus.PC_write && !bus.Branch2;

    // Next-PC selection: branch, then hold, then jump, then sequential
    always_comb begin
        next_pc_s = pc4_s;
        if (bus.Branch2) begin
            next_pc_s = bus.BranchTarget;
        end else if (!bus.PC_write) begin
            next_pc_s = pc_r;
        end else if (bus.Jump) begin
            next_pc_s = bus.JumpTarget;
        end else begin
            next_pc_s = pc4_s;
        end
    end

    // IF/ID next contents: flush beats write, otherwise hold
    always_comb begin
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc4_nxt_s   = ifid_pc4_r;
        ifid_valid_nxt_s = ifid_valid_r;
        if (bus.IFID_flush) begin
            ifid_instr_nxt_s = NOP_INSTR;
            ifid_pc4_nxt_s   = 32'h0000_0000;
            ifid_valid_nxt_s = 1'b0;
        end else if (bus.IFID_write) begin
            ifid_instr_nxt_s = bus.Instr_in;
            ifid_pc4_nxt_s   = pc4_s;
            ifid_valid_nxt_s = 1'b1;
        end else begin
            ifid_instr_nxt_s = ifid_instr_r;
            ifid_pc4_nxt_s   = ifid_pc4_r;
            ifid_valid_nxt_s = ifid_valid_r;
        end
    end

    // Saturating event counter updates
    always_comb begin
        stall_cnt_nxt_s = stall_cnt_r;
        flush_cnt_nxt_s = flush_cnt_r;
        if (stall_s) begin
            stall_cnt_nxt_s = sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_nxt_s = stall_cnt_r;
        end
        if (bus.IFID_flush) begin
            flush_cnt_nxt_s = sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_nxt_s = flush_cnt_r;
        end
    end

    // State registers; reset also drops any redirect presented in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            stall_cnt_r  <= {CNT_W{1'b0}};
            flush_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            pc_r         <= next_pc_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc4_r   <= ifid_pc4_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            stall_cnt_r  <= stall_cnt_nxt_s;
            flush_cnt_r  <= flush_cnt_nxt_s;
        end
    end

    assign bus.PC         = pc_r;
    assign bus.IFID_Instr = ifid_instr_r;
    assign bus.IFID_PC4   = ifid_pc4_r;
    assign bus.IFID_valid = ifid_valid_r;
    assign bus.stall_cnt  = stall_cnt_r;
    assign bus.flush_cnt  = flush_cnt_r;

endmodule

// File: tb/tb_ifid_fetch_pipe.sv
// Randomized self-checking bench for ifid_fetch_pipe: a 16-bit-counter instance and a
// 4-bit-counter instance share stimulus and are compared against a behavioural model.
module tb_ifid_fetch_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        pc_write, ifid_write, ifid_flush, branch2, jump;
    logic [31:0] branch_target, jump_target, instr_in;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_stall, m_flush, m_stall4, m_flush4;

    ifid_fetch_pipe_if #(.CNT_W(16)) bus16 ();
    ifid_fetch_pipe_if #(.CNT_W(4))  bus4 ();

    assign bus16.PC_write = pc_write;       assign bus4.PC_write = pc_write;
    assign bus16.IFID_write = ifid_write;   assign bus4.IFID_write = ifid_write;
    assign bus16.IFID_flush = ifid_flush;   assign bus4.IFID_flush = ifid_flush;
    assign bus16.Branch2 = branch2;         assign bus4.Branch2 = branch2;
    assign bus16.BranchTarget = branch_target; assign bus4.BranchTarget = branch_target;
    assign bus16.Jump = jump;               assign bus4.Jump = jump;
    assign bus16.JumpTarget = jump_target;  assign bus4.JumpTarget = jump_target;
    assign bus16.Instr_in = instr_in;       assign bus4.Instr_in = instr_in;

    ifid_fetch_pipe #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(16))
        dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    ifid_fetch_pipe #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(4))
        dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic idle();
        pc_write = 1'b1; ifid_write = 1'b1; ifid_flush = 1'b0;
        branch2 = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; instr_in = $urandom;
    endtask

    // one rising edge; model advances from the inputs present at that edge
    task automatic cycle();
        logic [31:0] seq;
        @(posedge clk);
        seq = m_pc + 32'd4;
        if (ifid_flush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (ifid_write) begin
            m_instr = instr_in; m_pc4 = seq; m_valid = 1'b1;
        end
        if (!pc_write && !branch2) begin
            m_stall  = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
            m_stall4 = (m_stall4 + 1 > 15) ? 15 : m_stall4 + 1;
        end
        if (ifid_flush) begin
            m_flush  = (m_flush + 1 > 65535) ? 65535 : m_flush + 1;
            m_flush4 = (m_flush4 + 1 > 15) ? 15 : m_flush4 + 1;
        end
        if (branch2)        m_pc = branch_target;
        else if (!pc_write) m_pc = m_pc;
        else if (jump)      m_pc = jump_target;
        else                m_pc = seq;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        #12;
        model_reset();
        n_checks++; if (bus16.PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus16.PC); end
        n_checks++; if (bus16.IFID_Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus16.IFID_Instr); end
        n_checks++; if (bus16.IFID_PC4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", bus16.IFID_PC4); end
        n_checks++; if (bus16.IFID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus16.IFID_valid); end
        n_checks++; if (bus16.stall_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stall got %h want 0", bus16.stall_cnt); end
        n_checks++; if (bus16.flush_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_flush got %h want 0", bus16.flush_cnt); end
        n_checks++; if (bus4.flush_cnt !== 4'h0 || bus4.stall_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt4 got %h/%h want 0/0", bus4.stall_cnt, bus4.flush_cnt); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 3; i++) begin
            idle();
            instr_in = 32'h2008_0001;
            cycle();
            n_checks++; if (bus16.PC !== 32'(4 * i)) begin n_fail++; $display("FAIL free_pc got %h want %h", bus16.PC, 32'(4 * i)); end
            n_checks++; if (bus16.IFID_Instr !== 32'h2008_0001) begin n_fail++; $display("FAIL free_instr got %h want 20080001", bus16.IFID_Instr); end
            n_checks++; if (bus16.IFID_PC4 !== 32'(4 * i)) begin n_fail++; $display("FAIL free_pc4 got %h want %h", bus16.IFID_PC4, 32'(4 * i)); end
            n_checks++; if (bus16.IFID_valid !== 1'b1) begin n_fail++; $display("FAIL free_valid got %b want 1", bus16.IFID_valid); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        idle(); cycle();
        n_checks++; if (bus16.PC !== 32'h10) begin n_fail++; $display("FAIL stall_setup_pc got %h want 10", bus16.PC); end
        held = m_instr;
        idle(); pc_write = 1'b0; ifid_write = 1'b0;
        cycle();
        n_checks++; if (bus16.PC !== 32'h10) begin n_fail++; $display("FAIL stall_pc got %h want 10", bus16.PC); end
        n_checks++; if (bus16.IFID_Instr !== held || bus16.IFID_PC4 !== 32'h10) begin n_fail++; $display("FAIL stall_ifid got %h/%h want %h/10", bus16.IFID_Instr, bus16.IFID_PC4, held); end
        n_checks++; if (bus16.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt got %0d want 1", bus16.stall_cnt); end
        n_checks++; if (bus16.flush_cnt !== 16'd0) begin n_fail++; $display("FAIL stall_flush got %0d want 0", bus16.flush_cnt); end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 4; i++) begin idle(); cycle(); end
        n_checks++; if (bus16.PC !== 32'h20) begin n_fail++; $display("FAIL jump_setup_pc got %h want 20", bus16.PC); end
        idle(); jump = 1'b1; jump_target = 32'h100; ifid_flush = 1'b1;
        cycle();
        n_checks++; if (bus16.PC !== 32'h100) begin n_fail++; $display("FAIL jump_pc got %h want 100", bus16.PC); end
        n_checks++; if (bus16.IFID_valid !== 1'b0 || bus16.IFID_Instr !== 32'h0) begin n_fail++; $display("FAIL jump_bubble got %b/%h want 0/0", bus16.IFID_valid, bus16.IFID_Instr); end
        n_checks++; if (bus16.flush_cnt !== 16'd1) begin n_fail++; $display("FAIL jump_flush got %0d want 1", bus16.flush_cnt); end
    endtask

    task automatic test_branch();
        idle(); pc_write = 1'b0; branch2 = 1'b1; branch_target = 32'h40;
        jump = 1'b1; jump_target = 32'h80; ifid_flush = 1'b1;
        cycle();
        n_checks++; if (bus16.PC !== 32'h40) begin n_fail++; $display("FAIL branch_pc got %h want 40", bus16.PC); end
        n_checks++; if (bus16.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_stall got %0d want 1", bus16.stall_cnt); end
        n_checks++; if (bus16.flush_cnt !== 16'd2) begin n_fail++; $display("FAIL branch_flush got %0d want 2", bus16.flush_cnt); end
    endtask

    task automatic test_wrap();
        idle(); jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        cycle();
        n_checks++; if (bus16.PC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup_pc got %h want fffffffc", bus16.PC); end
        idle(); cycle();
        n_checks++; if (bus16.PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", bus16.PC); end
        n_checks++; if (bus16.IFID_PC4 !== 32'h0 || bus16.IFID_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc4 got %h/%b want 0/1", bus16.IFID_PC4, bus16.IFID_valid); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            idle(); ifid_flush = 1'b1;
            cycle();
            n_checks++; if (bus4.flush_cnt !== m_flush4[3:0]) begin n_fail++; $display("FAIL sat_flush4 got %h want %h", bus4.flush_cnt, m_flush4[3:0]); end
        end
        n_checks++; if (bus4.flush_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_final got %h want f", bus4.flush_cnt); end
        n_checks++; if (bus16.flush_cnt !== 16'd22) begin n_fail++; $display("FAIL sat_flush16 got %0d want 22", bus16.flush_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            pc_write      = ($urandom_range(0, 3) != 0);
            ifid_write    = ($urandom_range(0, 3) != 0);
            ifid_flush    = ($urandom_range(0, 4) == 0);
            branch2       = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_target   = $urandom & 32'hFFFF_FFFC;
            instr_in      = $urandom;
            cycle();
            n_checks++; if (bus16.PC !== m_pc) begin n_fail++; $display("FAIL rand_pc cyc %0d got %h want %h", i, bus16.PC, m_pc); end
            n_checks++; if (bus16.IFID_Instr !== m_instr) begin n_fail++; $display("FAIL rand_instr cyc %0d got %h want %h", i, bus16.IFID_Instr, m_instr); end
            n_checks++; if (bus16.IFID_PC4 !== m_pc4) begin n_fail++; $display("FAIL rand_pc4 cyc %0d got %h want %h", i, bus16.IFID_PC4, m_pc4); end
            n_checks++; if (bus16.IFID_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid cyc %0d got %b want %b", i, bus16.IFID_valid, m_valid); end
            n_checks++; if (bus16.stall_cnt !== m_stall[15:0] || bus16.flush_cnt !== m_flush[15:0]) begin n_fail++; $display("FAIL rand_cnt16 cyc %0d got %0d/%0d want %0d/%0d", i, bus16.stall_cnt, bus16.flush_cnt, m_stall, m_flush); end
            n_checks++; if (bus4.stall_cnt !== m_stall4[3:0] || bus4.flush_cnt !== m_flush4[3:0]) begin n_fail++; $display("FAIL rand_cnt4 cyc %0d got %0d/%0d want %0d/%0d", i, bus4.stall_cnt, bus4.flush_cnt, m_stall4, m_flush4); end
        end
    endtask

    task automatic test_async_reset();
        idle(); pc_write = 1'b0; ifid_write = 1'b0;
        branch2 = 1'b1; branch_target = 32'h0000_0800; // pending redirect must be discarded
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++; if (bus16.PC !== 32'h0 || bus16.IFID_valid !== 1'b0 || bus16.IFID_PC4 !== 32'h0) begin n_fail++; $display("FAIL areset_out got %h/%b/%h want 0/0/0", bus16.PC, bus16.IFID_valid, bus16.IFID_PC4); end
        n_checks++; if (bus16.stall_cnt !== 16'h0 || bus16.flush_cnt !== 16'h0) begin n_fail++; $display("FAIL areset_cnt got %0d/%0d want 0/0", bus16.stall_cnt, bus16.flush_cnt); end
        @(posedge clk); #3;
        reset = 1'b0;
        idle();
        cycle();
        n_checks++; if (bus16.PC !== 32'h4) begin n_fail++; $display("FAIL areset_first got %h want 4", bus16.PC); end
        n_checks++; if (bus16.IFID_PC4 !== 32'h4 || bus16.IFID_valid !== 1'b1) begin n_fail++; $display("FAIL areset_ifid got %h/%b want 4/1", bus16.IFID_PC4, bus16.IFID_valid); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        model_reset();
        test_reset();
        test_free_run();
        test_stall();
        test_jump();
        test_branch();
        test_wrap();
        test_saturation();
        test_random();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
